// File: rtl/csr_pkg.sv
// Shared CSR-side constants for the interrupt path: interrupt bit positions
// in mip/mie, the matching exception codes, the mtvec mode field values and
// the interrupt controller state encoding.
package csr_pkg;

   // Bit positions in mip / mie
   localparam int unsigned IRQ_USI = 0;
   localparam int unsigned IRQ_SSI = 1;
   localparam int unsigned IRQ_MSI = 3;
   localparam int unsigned IRQ_UTI = 4;
   localparam int unsigned IRQ_STI = 5;
   localparam int unsigned IRQ_MTI = 7;
   localparam int unsigned IRQ_UEI = 8;
   localparam int unsigned IRQ_SEI = 9;
   localparam int unsigned IRQ_MEI = 11;

   // Exception codes reported in mcause for each interrupt source
   localparam logic [4:0] CODE_USI = 5'd0;
   localparam logic [4:0] CODE_SSI = 5'd1;
   localparam logic [4:0] CODE_MSI = 5'd3;
   localparam logic [4:0] CODE_UTI = 5'd4;
   localparam logic [4:0] CODE_STI = 5'd5;
   localparam logic [4:0] CODE_MTI = 5'd7;
   localparam logic [4:0] CODE_UEI = 5'd8;
   localparam logic [4:0] CODE_SEI = 5'd9;
   localparam logic [4:0] CODE_MEI = 5'd11;

   // Only these mip bits carry an implemented interrupt source
   localparam logic [31:0] IRQ_IMPL_MASK = 32'h0000_0BBB;

   // mtvec[1:0] mode field
   localparam logic [1:0] MTVEC_VECTORED = 2'b01;

   // mepc is always word aligned
   localparam logic [31:0] EPC_ALIGN_MASK = 32'hFFFF_FFFC;

   // mcause interrupt flag with a zero code, also the reset value of mcause_out
   localparam logic [31:0] MCAUSE_IRQ_BIT = 32'h8000_0000;

   // Interrupt controller state encoding
   typedef logic [1:0] irq_state_t;
   localparam irq_state_t ST_IDLE  = 2'd0;
   localparam irq_state_t ST_REQ   = 2'd1;
   localparam irq_state_t ST_ENTER = 2'd2;
   localparam irq_state_t ST_COOL  = 2'd3;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder over the enabled-pending vector. Picks the single
// interrupt to take using the machine-mode priority order
// MEI > MSI > MTI > SEI > SSI > STI > UEI > USI > UTI.
// Unimplemented bit positions never win. Shared with the exception/trap unit.
module irq_prio_enc
   import csr_pkg::*;
(
   input  logic [31:0] pend,
   output logic        any,
   output logic [4:0]  code
);

   // Highest-priority pending source wins; code is 0 when nothing is pending
   always_comb begin
      any  = |(pend & IRQ_IMPL_MASK);
      code = 5'd0;
      if (pend[IRQ_MEI]) begin
         code = CODE_MEI;
      end else if (pend[IRQ_MSI]) begin
         code = CODE_MSI;
      end else if (pend[IRQ_MTI]) begin
         code = CODE_MTI;
      end else if (pend[IRQ_SEI]) begin
         code = CODE_SEI;
      end else if (pend[IRQ_SSI]) begin
         code = CODE_SSI;
      end else if (pend[IRQ_STI]) begin
         code = CODE_STI;
      end else if (pend[IRQ_UEI]) begin
         code = CODE_UEI;
      end else if (pend[IRQ_USI]) begin
         code = CODE_USI;
      end else if (pend[IRQ_UTI]) begin
         code = CODE_UTI;
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Machine interrupt controller. Registers the enabled pending set, arbitrates
// it by fixed priority, requests a trap from the pipeline front end and, once
// the request is accepted, issues a one-cycle trap-entry command to the CSR
// file (mepc, mcause, mstatus MIE->MPIE, redirect PC).
//
// Handshake with the front end: irq_valid/irq_cause are driven from state
// only. A request is accepted in any cycle where irq_valid=1, irq_ready=1 and
// exc_valid=0; a synchronous exception always wins over the interrupt. While
// not accepted the request may be withdrawn (its source no longer enabled and
// pending) or retargeted to a higher-priority source, so irq_cause is only
// stable from the accepting cycle onward. Acceptance beats withdrawal.
//
// The FSM state is held in state_q (IDLE/REQ/ENTER/COOL) for observation.
module irq_ctrl
   import csr_pkg::*;
#(
   parameter logic VECTORED_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mip,
   input  logic [31:0] mie,
   input  logic        mstatus_mie,
   input  logic [31:0] mtvec,
   input  logic        irq_ready,
   input  logic        exc_valid,
   input  logic [31:0] epc_in,
   output logic        irq_valid,
   output logic [4:0]  irq_cause,
   output logic        trap_we,
   output logic [31:0] mepc_out,
   output logic [31:0] mcause_out,
   output logic [31:0] trap_pc
);

   irq_state_t  state_q,        state_d;
   logic [31:0] pend_q,         pend_d;
   logic [4:0]  cause_q,        cause_d;
   logic [31:0] epc_q,          epc_d;
   logic [31:0] mepc_hold_q,    mepc_hold_d;
   logic [31:0] mcause_hold_q,  mcause_hold_d;
   logic [31:0] trap_pc_hold_q, trap_pc_hold_d;

   logic        win_any;
   logic [4:0]  win_code;
   logic        cause_pend;
   logic        accept;
   logic        vec_mode;
   logic [31:0] trap_base;
   logic [31:0] trap_pc_calc;
   logic [31:0] mcause_calc;

   irq_prio_enc u_prio_enc (
      .pend (pend_q),
      .any  (win_any),
      .code (win_code)
   );

   // Stage 1: enabled pending set, gated by the global machine enable
   always_comb begin
      pend_d = mip & mie & {32{mstatus_mie}};
   end

   // Handshake terms and trap target computation
   always_comb begin
      cause_pend   = pend_q[cause_q];
      accept       = (state_q == ST_REQ) && irq_ready && !exc_valid;
      vec_mode     = VECTORED_EN && (mtvec[1:0] == MTVEC_VECTORED);
      trap_base    = {mtvec[31:2], 2'b00};
      trap_pc_calc = vec_mode ? (trap_base + {25'd0, cause_q, 2'b00}) : trap_base;
      mcause_calc  = {1'b1, 26'd0, cause_q};
   end

   // Request/entry sequencing: pick a winner, hold the request until it is
   // accepted, withdrawn or retargeted, then strobe entry and cool down
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      epc_d   = epc_q;
      case (state_q)
         ST_IDLE: begin
            if (win_any) begin
               cause_d = win_code;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (accept) begin
               epc_d   = epc_in & EPC_ALIGN_MASK;
               state_d = ST_ENTER;
            end else if (!cause_pend) begin
               state_d = ST_IDLE;
            end else if (win_code != cause_q) begin
               // The current cause is still pending, so any different winner
               // outranks it.
               cause_d = win_code;
            end
         end
         ST_ENTER: begin
            state_d = ST_COOL;
         end
         ST_COOL: begin
            // One quiet cycle so pend_q picks up the MIE clear from entry
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Capture the entry command so the CSR-facing outputs hold afterwards
   always_comb begin
      mepc_hold_d    = mepc_hold_q;
      mcause_hold_d  = mcause_hold_q;
      trap_pc_hold_d = trap_pc_hold_q;
      if (state_q == ST_ENTER) begin
         mepc_hold_d    = epc_q;
         mcause_hold_d  = mcause_calc;
         trap_pc_hold_d = trap_pc_calc;
      end
   end

   // Output decode: live values during ENTER, held values otherwise
   always_comb begin
      irq_valid  = (state_q == ST_REQ);
      irq_cause  = cause_q;
      trap_we    = (state_q == ST_ENTER);
      mepc_out   = trap_we ? epc_q        : mepc_hold_q;
      mcause_out = trap_we ? mcause_calc  : mcause_hold_q;
      trap_pc    = trap_we ? trap_pc_calc : trap_pc_hold_q;
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         pend_q         <= 32'd0;
         cause_q        <= 5'd0;
         epc_q          <= 32'd0;
         mepc_hold_q    <= 32'd0;
         mcause_hold_q  <= MCAUSE_IRQ_BIT;
         trap_pc_hold_q <= 32'd0;
      end else begin
         state_q        <= state_d;
         pend_q         <= pend_d;
         cause_q        <= cause_d;
         epc_q          <= epc_d;
         mepc_hold_q    <= mepc_hold_d;
         mcause_hold_q  <= mcause_hold_d;
         trap_pc_hold_q <= trap_pc_hold_d;
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: directed scenarios followed by randomized traffic.
// A reference model pushes each predicted trap entry into exp_q; a monitor
// pops and compares on every trap_we strobe and also checks the request and
// hold outputs each cycle. A second instance runs in direct-only mode.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mip, mie, mtvec, epc_in;
   logic        mstatus_mie, irq_ready, exc_valid;

   logic        irq_valid, trap_we;
   logic [4:0]  irq_cause;
   logic [31:0] mepc_out, mcause_out, trap_pc;

   logic        d_irq_valid, d_trap_we;
   logic [4:0]  d_irq_cause;
   logic [31:0] d_mepc_out, d_mcause_out, d_trap_pc;

   int n_checks = 0;
   int n_errors = 0;
   int cyc_cnt  = 0;

   // {mepc, mcause, trap_pc vectored-capable, trap_pc direct-only}
   logic [127:0] exp_q[$];

   irq_ctrl #(.VECTORED_EN(1'b1)) u_dut (
      .clk(clk), .rst(rst), .mip(mip), .mie(mie), .mstatus_mie(mstatus_mie),
      .mtvec(mtvec), .irq_ready(irq_ready), .exc_valid(exc_valid), .epc_in(epc_in),
      .irq_valid(irq_valid), .irq_cause(irq_cause), .trap_we(trap_we),
      .mepc_out(mepc_out), .mcause_out(mcause_out), .trap_pc(trap_pc)
   );

   irq_ctrl #(.VECTORED_EN(1'b0)) u_dut_dir (
      .clk(clk), .rst(rst), .mip(mip), .mie(mie), .mstatus_mie(mstatus_mie),
      .mtvec(mtvec), .irq_ready(irq_ready), .exc_valid(exc_valid), .epc_in(epc_in),
      .irq_valid(d_irq_valid), .irq_cause(d_irq_cause), .trap_we(d_trap_we),
      .mepc_out(d_mepc_out), .mcause_out(d_mcause_out), .trap_pc(d_trap_pc)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   int prio_list[9] = '{11, 3, 7, 9, 1, 5, 8, 0, 4};

   function automatic int best_irq(input logic [31:0] p);
      for (int i = 0; i < 9; i++) begin
         if (p[prio_list[i]]) return prio_list[i];
      end
      return -1;
   endfunction

   // ---------------- reference model ----------------
   // phase: 0 waiting, 1 requesting, 2 entering, 3 cooling down
   int          m_phase    = 0;
   logic [31:0] m_pend     = '0;
   logic [4:0]  m_cause    = '0;
   logic [31:0] m_hold_mepc   = '0;
   logic [31:0] m_hold_mcause = 32'h8000_0000;
   logic [31:0] m_hold_pc     = '0;
   logic [31:0] m_hold_pc_dir = '0;
   logic [127:0] m_entry   = '0;

   always @(posedge clk) begin
      logic [31:0] old_pend;
      logic [31:0] base, pc_vec;
      int          w;
      if (rst) begin
         m_phase       = 0;
         m_pend        = '0;
         m_cause       = '0;
         m_hold_mepc   = '0;
         m_hold_mcause = 32'h8000_0000;
         m_hold_pc     = '0;
         m_hold_pc_dir = '0;
      end else begin
         old_pend = m_pend;
         m_pend   = mip & mie & {32{mstatus_mie}};
         case (m_phase)
            0: begin
               w = best_irq(old_pend);
               if (w >= 0) begin
                  m_cause = w[4:0];
                  m_phase = 1;
               end
            end
            1: begin
               if (irq_ready && !exc_valid) begin
                  base    = mtvec & 32'hFFFF_FFFC;
                  pc_vec  = (mtvec[1:0] == 2'b01) ? base + 32'(m_cause) * 4 : base;
                  m_entry = {epc_in & 32'hFFFF_FFFC, 32'h8000_0000 | 32'(m_cause), pc_vec, base};
                  exp_q.push_back(m_entry);
                  m_phase = 2;
               end else if (!old_pend[m_cause]) begin
                  m_phase = 0;
               end else begin
                  w = best_irq(old_pend);
                  m_cause = w[4:0];
               end
            end
            2: begin
               m_hold_mepc   = m_entry[127:96];
               m_hold_mcause = m_entry[95:64];
               m_hold_pc     = m_entry[63:32];
               m_hold_pc_dir = m_entry[31:0];
               m_phase = 3;
            end
            default: m_phase = 0;
         endcase
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(posedge clk) begin
      logic [127:0] e;
      #1;
      chk("irq_valid", irq_valid, m_phase == 1);
      chk("irq_cause", irq_cause, m_cause);
      chk("trap_we", trap_we, m_phase == 2);
      chk("dir irq_valid", d_irq_valid, m_phase == 1);
      chk("dir irq_cause", d_irq_cause, m_cause);
      chk("dir trap_we", d_trap_we, m_phase == 2);
      if (trap_we) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL trap_entry: strobe with no expected entry, got 1 expected 0 (t=%0t)", $time);
         end else begin
            e = exp_q.pop_front();
            chk("mepc_out", mepc_out, e[127:96]);
            chk("mcause_out", mcause_out, e[95:64]);
            chk("trap_pc", trap_pc, e[63:32]);
            chk("dir mepc_out", d_mepc_out, e[127:96]);
            chk("dir mcause_out", d_mcause_out, e[95:64]);
            chk("dir trap_pc", d_trap_pc, e[31:0]);
         end
      end else begin
         chk("hold mepc_out", mepc_out, m_hold_mepc);
         chk("hold mcause_out", mcause_out, m_hold_mcause);
         chk("hold trap_pc", trap_pc, m_hold_pc);
         chk("dir hold trap_pc", d_trap_pc, m_hold_pc_dir);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic quiesce(input int n);
      @(negedge clk);
      mip = '0; exc_valid = 1'b0; irq_ready = 1'b0; rst = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Wait (bounded) for a trap strobe; returns at posedge+1 of the strobe
   task automatic wait_trap(input int max_cyc, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge clk);
         #1;
         if (trap_we) begin
            seen = 1'b1;
            return;
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit seen;
      int t0;

      rst = 1'b1; mip = '0; mie = '0; mstatus_mie = 1'b0; mtvec = '0;
      irq_ready = 1'b0; exc_valid = 1'b0; epc_in = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("reset irq_valid", irq_valid, 0);
      chk("reset irq_cause", irq_cause, 0);
      chk("reset trap_we", trap_we, 0);
      chk("reset mcause_out", mcause_out, 32'h8000_0000);
      chk("reset mepc_out", mepc_out, 0);
      chk("reset trap_pc", trap_pc, 0);

      // Basic MTI: request two cycles after mip, entry on the next
      @(negedge clk);
      mstatus_mie = 1'b1; mie = 32'h080; mip = 32'h080; irq_ready = 1'b1;
      epc_in = 32'h0000_1004; mtvec = 32'h0000_0100;
      @(posedge clk); #1;
      chk("mti latency c1 valid", irq_valid, 0);
      @(posedge clk); #1;
      chk("mti c2 valid", irq_valid, 1);
      chk("mti c2 cause", irq_cause, 7);
      @(posedge clk); #1;
      chk("mti c3 trap_we", trap_we, 1);
      chk("mti mepc", mepc_out, 32'h0000_1004);
      chk("mti mcause", mcause_out, 32'h8000_0007);
      chk("mti trap_pc", trap_pc, 32'h0000_0100);
      quiesce(4);

      // Priority: MEI, then MSI, then MTI, back to back
      mip = 32'h888; mie = 32'h888; irq_ready = 1'b1; epc_in = 32'h0000_2002;
      wait_trap(10, seen);
      chk("prio trap1 seen", seen, 1);
      chk("prio trap1 mcause", mcause_out, 32'h8000_000B);
      chk("prio trap1 mepc aligned", mepc_out, 32'h0000_2000);
      t0 = cyc_cnt;
      @(negedge clk); mip = 32'h088;
      wait_trap(10, seen);
      chk("prio trap2 seen", seen, 1);
      chk("prio trap2 mcause", mcause_out, 32'h8000_0003);
      chk("prio spacing", cyc_cnt - t0, 4);
      @(negedge clk); mip = 32'h080;
      wait_trap(10, seen);
      chk("prio trap3 seen", seen, 1);
      chk("prio trap3 mcause", mcause_out, 32'h8000_0007);
      quiesce(4);

      // Vectored mode (direct-only instance checked by the monitor)
      mtvec = 32'h0000_0201; mip = 32'h008; mie = 32'h008; irq_ready = 1'b1;
      wait_trap(10, seen);
      chk("vec seen", seen, 1);
      chk("vec trap_pc", trap_pc, 32'h0000_020C);
      chk("direct trap_pc", d_trap_pc, 32'h0000_0200);
      quiesce(4);

      // Vectored target wraps at 32 bits
      mtvec = 32'hFFFF_FFE1; mip = 32'h800; mie = 32'h800; irq_ready = 1'b1;
      wait_trap(10, seen);
      chk("wrap seen", seen, 1);
      chk("wrap trap_pc", trap_pc, 32'h0000_000C);
      quiesce(4);
      mtvec = 32'h0000_0100;

      // Exception priority holds the request, then withdrawal
      mip = 32'h080; mie = 32'h080; irq_ready = 1'b1; exc_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("exc req valid", irq_valid, 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("exc no trap_we", trap_we, 0);
         chk("exc valid held", irq_valid, 1);
      end
      @(negedge clk);
      mie = 32'h000; irq_ready = 1'b0; exc_valid = 1'b0;
      @(posedge clk); #1;
      chk("withdraw c1 valid", irq_valid, 1);
      @(posedge clk); #1;
      chk("withdraw c2 valid", irq_valid, 0);
      quiesce(4);

      // Acceptance wins over a same-cycle withdrawal
      mip = 32'h080; mie = 32'h080; irq_ready = 1'b0; epc_in = 32'h0000_3008;
      repeat (2) @(posedge clk);
      @(negedge clk); mip = 32'h000;
      @(negedge clk); irq_ready = 1'b1;
      @(posedge clk); #1;
      chk("accept over withdraw trap_we", trap_we, 1);
      chk("accept over withdraw mepc", mepc_out, 32'h0000_3008);
      quiesce(4);

      // Global disable
      mstatus_mie = 1'b0; mip = 32'hFFF; mie = 32'hFFF; irq_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("global disable valid", irq_valid, 0);
      end
      quiesce(2);
      mstatus_mie = 1'b1;

      // Reset during ENTER
      mip = 32'h080; mie = 32'h080; irq_ready = 1'b1; epc_in = 32'h0000_4000;
      wait_trap(10, seen);
      chk("rst enter seen", seen, 1);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("rst mid trap_we", trap_we, 0);
      chk("rst mid irq_valid", irq_valid, 0);
      chk("rst mid mcause", mcause_out, 32'h8000_0000);
      chk("rst mid trap_pc", trap_pc, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("post rst resample valid", irq_valid, 0);
      @(posedge clk); #1;
      chk("post rst request valid", irq_valid, 1);
      quiesce(6);

      // Randomized traffic, two vector bases
      for (int blk = 0; blk < 2; blk++) begin
         mtvec = (blk == 0) ? 32'h0000_8001 : 32'h0001_0000;
         for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) == 0) mip = $urandom & $urandom;
            mie         = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFF;
            mstatus_mie = ($urandom_range(0, 7) != 0);
            irq_ready   = $urandom_range(0, 1);
            exc_valid   = ($urandom_range(0, 3) == 0);
            epc_in      = $urandom;
            rst         = ($urandom_range(0, 99) == 0);
            @(negedge clk);
         end
         quiesce(6);
      end

      chk("scoreboard drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
